// File: rtl/alu_result_stage.sv
// alu_result_stage: registered execute stage of the 8-bit ALU.
// Computes add/sub/AND/OR on A and the pre-conditioned B_S, producing Result
// and {N,Z,C,V}. The output side is a valid/ready interface backed by a
// 2-entry skid buffer (main + skid). Because of the skid entry, in_ready is a
// pure decode of the state register and never depends on out_ready.
module alu_result_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] A,
    input  logic [7:0] B_S,
    input  logic [1:0] ALUControl,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Result,
    output logic [3:0] Flags
);

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;

    // One buffered response: result word plus {N, Z, C, V}
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [FLAG_W-1:0] flags;
    } bundle_t;

    // EMPTY: nothing held; ONE: main valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // 9-bit sum; the top bit is the carry out (for sub: 1 means no borrow).
    // B_S already carries the inversion, so carry-in completes the negate.
    function automatic logic [DATA_W:0] add_with_carry(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              cin
    );
        logic [DATA_W:0] a_ext;
        logic [DATA_W:0] b_ext;
        logic [DATA_W:0] c_ext;
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        c_ext = {{DATA_W{1'b0}}, cin};
        return a_ext + b_ext + c_ext;
    endfunction

    // Two's-complement overflow: operands share a sign, result sign differs
    function automatic logic signed_overflow(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] r
    );
        logic a_neg;
        logic b_neg;
        logic r_neg;
        a_neg = (a < 0);
        b_neg = (b < 0);
        r_neg = (r < 0);
        return (a_neg == b_neg) && (r_neg != a_neg);
    endfunction

    // Full compute for one operand bundle, op select in ctl
    function automatic bundle_t alu_compute(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [1:0]        ctl
    );
        bundle_t         o;
        logic [DATA_W:0] sum;
        logic            n_f;
        logic            z_f;
        logic            c_f;
        logic            v_f;
        sum = add_with_carry(a, b, ctl[0]);
        c_f = 1'b0;
        v_f = 1'b0;
        unique case (ctl)
            2'b00, 2'b01: begin
                o.res = sum[DATA_W-1:0];
                c_f   = sum[DATA_W];
                v_f   = signed_overflow($signed(a), $signed(b), $signed(sum[DATA_W-1:0]));
            end
            2'b10:   o.res = a & b;
            default: o.res = a | b;
        endcase
        n_f     = o.res[DATA_W-1];
        z_f     = (o.res == '0);
        o.flags = {n_f, z_f, c_f, v_f};
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t  state;
    state_t  state_nxt;

    bundle_t comp_p0;   // combinational result of the presented bundle
    bundle_t main_p1;   // head entry, drives Result/Flags
    bundle_t skid_p1;   // overflow entry captured under backpressure

    logic    accept;
    logic    fire;
    logic    load_main_comp;
    logic    load_main_skid;
    logic    load_skid_comp;

    // ------------------------------------------------------------------
    // Stage p0: combinational compute and handshake decode
    // ------------------------------------------------------------------
    assign comp_p0   = alu_compute(A, B_S, ALUControl);

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);

    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    // Next-state and load-enable decode for the 2-entry buffer
    always_comb begin
        state_nxt      = state;
        load_main_comp = 1'b0;
        load_main_skid = 1'b0;
        load_skid_comp = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt      = ONE;
                    load_main_comp = 1'b1;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    load_main_comp = 1'b1;
                end else if (accept) begin
                    state_nxt      = FULL;
                    load_skid_comp = 1'b1;
                end else if (fire) begin
                    state_nxt      = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage p1: registered buffer entries
    // ------------------------------------------------------------------

    // State register; reset discards whatever is held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Main entry: refilled from compute or promoted from skid; holds otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_p1 <= '0;
        end else if (load_main_comp) begin
            main_p1 <= comp_p0;
        end else if (load_main_skid) begin
            main_p1 <= skid_p1;
        end
    end

    // Skid entry: captures the second bundle while the head is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_p1 <= '0;
        end else if (load_skid_comp) begin
            skid_p1 <= comp_p0;
        end
    end

    assign Result = main_p1.res;
    assign Flags  = main_p1.flags;

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed vectors with hand-computed
// expectations pushed to a scoreboard; a monitor pops on every fire.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B_S;
    logic [1:0] ALUControl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic [3:0] Flags;

    int n_pass  = 0;
    int n_total = 0;
    logic [11:0] exp_q[$];

    alu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B_S        (B_S),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Flags      (Flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Offer one bundle at a negedge, wait (bounded) for in_ready, record expectation
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                        input logic [7:0] er, input logic [3:0] ef);
        int n;
        n = 0;
        A = a; B_S = b; ALUControl = c; in_valid = 1'b1;
        while (!in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
        end else begin
            exp_q.push_back({er, ef});
        end
        @(negedge clk);
    endtask

    // Monitor: values sampled here are what the next rising edge will see
    always @(negedge clk) begin
        logic [11:0] e;
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_output: got Result=%0h Flags=%0h, required no output", Result, Flags);
            end else begin
                e = exp_q.pop_front();
                check("result", {24'd0, Result}, {24'd0, e[11:4]});
                check("flags",  {28'd0, Flags},  {28'd0, e[3:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = 8'h00; B_S = 8'h00; ALUControl = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 0);
        check("reset_in_ready",  {31'd0, in_ready},  1);
        check("reset_result",    {24'd0, Result},    0);
        check("reset_flags",     {28'd0, Flags},     0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-op vectors, one-cycle latency
        out_ready = 1'b1;
        send(8'h7F, 8'h01, 2'b00, 8'h80, 4'b1001);
        check("latency_valid", {31'd0, out_valid}, 1);
        check("latency_result", {24'd0, Result}, 32'h80);
        send(8'h05, 8'hFA, 2'b01, 8'h00, 4'b0110);
        send(8'h03, 8'hFA, 2'b01, 8'hFE, 4'b1000);
        send(8'hF0, 8'h3C, 2'b10, 8'h30, 4'b0000);
        send(8'hF0, 8'h3C, 2'b11, 8'hFC, 4'b1000);
        in_valid = 1'b0;
        @(negedge clk);

        // Streaming: one result per cycle, in_ready stays high
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready", {31'd0, in_ready}, 1);
            send(8'(i), 8'(i), 2'b00, 8'(2 * i), (i == 0) ? 4'b0100 : 4'b0000);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_out_valid", {31'd0, out_valid}, 0);
        check("hold_result",    {24'd0, Result},    32'h0E);

        // Backpressure: two absorbed, third stalls until release
        out_ready = 1'b0;
        send(8'h10, 8'h20, 2'b00, 8'h30, 4'b0000);
        send(8'hFF, 8'h01, 2'b00, 8'h00, 4'b0110);
        A = 8'h80; B_S = 8'h80; ALUControl = 2'b00; in_valid = 1'b1;
        check("full_in_ready",  {31'd0, in_ready},  0);
        check("full_out_valid", {31'd0, out_valid}, 1);
        check("full_head",      {24'd0, Result},    32'h30);
        @(negedge clk);
        check("stall_in_ready", {31'd0, in_ready}, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready}, 1);
        check("release_head",     {24'd0, Result},   32'h00);
        send(8'h80, 8'h80, 2'b00, 8'h00, 4'b0111);
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_out_valid", {31'd0, out_valid}, 0);

        // Reset while FULL discards everything
        out_ready = 1'b0;
        send(8'h01, 8'h01, 2'b00, 8'h02, 4'b0000);
        send(8'h02, 8'h02, 2'b00, 8'h04, 4'b0000);
        check("prereset_in_ready", {31'd0, in_ready}, 0);
        A = 8'h33; B_S = 8'h11; rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("rst_full_out_valid", {31'd0, out_valid}, 0);
        check("rst_full_result",    {24'd0, Result},    0);
        check("rst_full_flags",     {28'd0, Flags},     0);
        check("rst_full_in_ready",  {31'd0, in_ready},  1);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_out", {31'd0, out_valid}, 0);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
